// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB requester.
package apb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StSetup  = 2'b01,
    StAccess = 2'b10
  } apb_state_e;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  function automatic int unsigned strb_width(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase watchdog: counts enabled cycles and flags the cycle that reaches the limit.
module apb_timeout_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the enabled cycle that would bring the count up to the limit.
  assign expired = en && ((cnt_q + CNT_W'(1)) >= limit);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB4 requester: valid/ready command in, one-cycle response pulse out.
// Optional ACCESS-phase timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [ADDR_W-1:0]             cmd_addr,
  input  logic [DATA_W-1:0]             cmd_wdata,
  input  logic [strb_width(DATA_W)-1:0] cmd_strb,
  input  logic [2:0]                    cmd_prot,
  output logic                          rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err,
  output logic [ADDR_W-1:0]             paddr,
  output logic                          pwrite,
  output logic [DATA_W-1:0]             pwdata,
  output logic [strb_width(DATA_W)-1:0] pstrb,
  output logic [2:0]                    pprot,
  output logic                          psel,
  output logic                          penable,
  input  logic [DATA_W-1:0]             prdata,
  input  logic                          pready,
  input  logic                          pslverr
);

  localparam int unsigned STRB_W = strb_width(DATA_W);

  apb_state_e        state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;
  logic [2:0]        pprot_q, pprot_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              cnt_clr, cnt_en, expired;

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    pprot_d     = pprot_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          pstrb_d  = cmd_write ? cmd_strb : '0;
          pprot_d  = cmd_prot;
          cnt_clr  = 1'b1;
          state_d  = StSetup;
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        if (pready) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          state_d     = StIdle;
        end else begin
          cnt_en = 1'b1;
          if (expired) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Phase outputs are registered copies of the next state.
    psel_d      = (state_d != StIdle);
    penable_d   = (state_d == StAccess);
    cmd_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= PROT_DEFAULT;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pprot_q     <= pprot_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  apb_timeout_cnt #(
    .CNT_W(CNT_W)
  ) u_timeout_cnt (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .limit   (CNT_W'(TIMEOUT_CYC)),
    .expired (expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^{cnt_clr, cnt_en, TIMEOUT_CYC};
  assign expired        = 1'b0;
`endif

  assign cmd_ready = cmd_ready_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign pprot     = pprot_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed plus randomized bench for apb_master with an in-bench APB slave and memory model.
module tb_apb_master;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic [2:0]    cmd_prot;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic [2:0]    pprot;
  logic          psel, penable;
  logic [DW-1:0] prdata;
  logic          pready, pslverr;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic [DW-1:0] mem [0:1023];

  apb_master #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (4)
  ) u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_strb  (cmd_strb),
    .cmd_prot  (cmd_prot),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .pprot     (pprot),
    .psel      (psel),
    .penable   (penable),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string ph, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [SW-1:0] st, input logic [2:0] pr);
    chk({ph, "_paddr"}, 64'(paddr), 64'(a));
    chk({ph, "_pwrite"}, 64'(pwrite), 64'(wr));
    chk({ph, "_pwdata"}, 64'(pwdata), 64'(wd));
    chk({ph, "_pstrb"}, 64'(pstrb), 64'(wr ? st : 4'h0));
    chk({ph, "_pprot"}, 64'(pprot), 64'(pr));
  endtask

  // Starts in a cycle where the requester is idle; ends in the response cycle.
  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input logic [SW-1:0] st, input logic [2:0] pr, input int waits,
                      input logic err, input logic [DW-1:0] rd, input bit noise_err,
                      input bit hold);
    chk("idle_ready", 64'(cmd_ready), 64'(1));
    chk("idle_psel", 64'(psel), 64'(0));
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_strb  = st;
    cmd_prot  = pr;
    tick();
    // Junk on the command port must be ignored until the next IDLE.
    cmd_valid = hold;
    cmd_write = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = $urandom;
    cmd_strb  = SW'($urandom);
    cmd_prot  = 3'($urandom);
    chk("setup_psel", 64'(psel), 64'(1));
    chk("setup_penable", 64'(penable), 64'(0));
    chk("setup_ready", 64'(cmd_ready), 64'(0));
    chk("setup_rsp", 64'(rsp_valid), 64'(0));
    chk_req("setup", wr, a, wd, st, pr);
    tick();
    for (int w = 0; w <= waits; w++) begin
      chk("access_psel", 64'(psel), 64'(1));
      chk("access_penable", 64'(penable), 64'(1));
      chk("access_ready", 64'(cmd_ready), 64'(0));
      chk("access_rsp", 64'(rsp_valid), 64'(0));
      chk_req("access", wr, a, wd, st, pr);
      pready  = (w == waits);
      pslverr = (w == waits) ? err : (noise_err ? 1'b1 : 1'($urandom));
      prdata  = (w == waits) ? rd : $urandom;
      tick();
    end
    pready  = 1'b0;
    pslverr = 1'($urandom);
    prdata  = $urandom;
    chk("rsp_valid", 64'(rsp_valid), 64'(1));
    chk("rsp_err", 64'(rsp_err), 64'(err));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(wr ? 32'h0 : rd));
    chk("rsp_psel", 64'(psel), 64'(0));
    chk("rsp_penable", 64'(penable), 64'(0));
    chk("rsp_ready", 64'(cmd_ready), 64'(1));
    chk("rsp_paddr_kept", 64'(paddr), 64'(a));
  endtask

  task automatic idle_cycle();
    tick();
    chk("idle_rsp_low", 64'(rsp_valid), 64'(0));
  endtask

  initial begin
    logic          wr, err;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, rd;
    logic [SW-1:0] st;
    logic [2:0]    pr;
    int            waits, n_acc;
    bit            seen;

    rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; cmd_prot = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;

    // Reset values
    #1;
    chk("rst_ready", 64'(cmd_ready), 64'(0));
    chk("rst_psel", 64'(psel), 64'(0));
    chk("rst_penable", 64'(penable), 64'(0));
    chk("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
    chk("rst_req", 64'({paddr, pwrite, pwdata, pstrb, pprot}), 64'(0));
    tick(); tick();
    rstn = 1'b1;
    tick();
    chk("post_rst_ready", 64'(cmd_ready), 64'(1));

    // Zero-wait write, two-wait read, error write, error noise ignored
    xfer(1'b1, 12'h010, 32'hA5A5_1234, 4'hF, 3'b000, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    idle_cycle();
    xfer(1'b0, 12'h010, 32'h0, 4'hF, 3'b010, 2, 1'b0, 32'hA5A5_1234, 1'b0, 1'b0);
    idle_cycle();
    xfer(1'b1, 12'h024, 32'hDEAD_BEEF, 4'h5, 3'b001, 1, 1'b1, 32'h0, 1'b1, 1'b0);
    idle_cycle();
    xfer(1'b1, 12'h028, 32'h1357_9BDF, 4'h3, 3'b111, 3, 1'b0, 32'h0, 1'b1, 1'b0);
    idle_cycle();

    // Back-to-back with cmd_valid held throughout
    xfer(1'b1, 12'h100, 32'h1111_1111, 4'hF, 3'b000, 0, 1'b0, 32'h0, 1'b0, 1'b1);
    xfer(1'b0, 12'h104, 32'h0, 4'h0, 3'b100, 1, 1'b0, 32'h2222_2222, 1'b0, 1'b1);
    xfer(1'b1, 12'h108, 32'h3333_3333, 4'hC, 3'b011, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    idle_cycle();

    // Reset pulsed during ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h3F0; cmd_prot = 3'b101;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("pre_rst_penable", 64'(penable), 64'(1));
    #2;
    rstn = 1'b0;
    #1;
    chk("async_psel", 64'(psel), 64'(0));
    chk("async_penable", 64'(penable), 64'(0));
    chk("async_ready", 64'(cmd_ready), 64'(0));
    chk("async_paddr", 64'(paddr), 64'(0));
    pready = 1'b1;
    tick();
    chk("in_rst_rsp", 64'(rsp_valid), 64'(0));
    pready = 1'b0;
    rstn = 1'b1;
    tick();
    chk("after_rst_rsp", 64'(rsp_valid), 64'(0));
    xfer(1'b0, 12'h3F0, 32'h0, 4'hF, 3'b101, 1, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0);
    idle_cycle();

    // Slave that never answers
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h200; cmd_prot = 3'b000;
    tick();
    cmd_valid = 1'b0;
    tick();
    n_acc = 0;
    seen  = 1'b0;
    for (int c = 0; c < 1000 && !seen; c++) begin
      if (penable) n_acc++;
      pslverr = 1'($urandom);
      prdata  = $urandom;
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    pslverr = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    chk("to_seen", 64'(seen), 64'(1));
    chk("to_access_cycles", 64'(n_acc), 64'(4));
    chk("to_err", 64'(rsp_err), 64'(1));
    chk("to_rdata", 64'(rsp_rdata), 64'(0));
    chk("to_psel", 64'(psel), 64'(0));
    idle_cycle();
`else
    chk("hang_no_rsp", 64'(seen), 64'(0));
    chk("hang_psel", 64'(psel), 64'(1));
    chk("hang_penable", 64'(penable), 64'(1));
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
`endif

    // Randomized traffic against the memory model
    for (int t = 0; t < 40; t++) begin
      wr    = 1'($urandom);
      a     = {10'($urandom), 2'b00};
      wd    = $urandom;
      st    = SW'($urandom);
      pr    = 3'($urandom);
      waits = int'($urandom_range(0, 3));
      err   = ($urandom_range(0, 4) == 0);
      rd    = mem[a[11:2]];
      xfer(wr, a, wd, st, pr, waits, err, rd, 1'b0, 1'b0);
      if (wr && !err) begin
        for (int b = 0; b < 4; b++) begin
          if (st[b]) mem[a[11:2]][8*b +: 8] = wd[8*b +: 8];
        end
      end
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
